// File: rtl/uart_pkt_parser_pkg.sv
// uart_pkt_parser_pkg: opcodes, header size and FSM state type for the UART packet parser
package uart_pkt_parser_pkg;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;
  localparam logic [7:0] OP_DIV  = 8'h8D;
  localparam int HDR_BYTES = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RSV,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_DRAIN
  } pkt_state_e;
  function automatic logic op_known(input logic [7:0] op);
    return op inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
  endfunction
endpackage

// File: rtl/uart_pkt_parser_idle_timer.sv
// uart_idle_timer: counts idle cycles between accepted bytes and flags the deadline
module uart_idle_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [31:0] cnt;
  // expired is gated by en so a frozen counter can never fire
  assign expired = en && (cnt == TIMEOUT_CYCLES - 32'd1);
  // idle counter: cleared on activity, frozen while not enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 32'd1;
  end
endmodule

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: parses 4-byte command headers from UART RX and frames the payload
module uart_pkt_parser
  import uart_pkt_parser_pkg::*;
#(
  parameter logic [15:0] MAX_LEN        = 16'd1024,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        hdr_valid_o,
  output logic [7:0]  opcode_o,
  output logic [15:0] len_o,
  output logic [7:0]  pay_data_o,
  output logic        pay_valid_o,
  input  logic        pay_ready_i,
  output logic        pay_last_o,
  output logic        op_err_o,
  output logic        len_err_o,
  output logic        abort_o
);
  pkt_state_e  state;
  logic [7:0]  op_r;
  logic [7:0]  len_lo;
  logic [15:0] rem;
  logic [15:0] len_w;
  logic        stalled;
  logic        accept;
  logic        expired;
  assign stalled = pay_valid_o & !pay_ready_i;
  // IDLE also waits for the last beat so a new header never overtakes the old payload
  assign rx_ready_o = (state == S_PAYLOAD || state == S_IDLE) ? !stalled : 1'b1;
  assign accept = rx_valid_i & rx_ready_o;
  assign len_w = {rx_data_i, len_lo};
  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (accept || state == S_IDLE),
    .en     (state != S_IDLE && !stalled),
    .expired(expired)
  );
  // packet FSM with registered pulses and the one-entry payload register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      op_r        <= '0;
      len_lo      <= '0;
      rem         <= '0;
      opcode_o    <= '0;
      len_o       <= '0;
      pay_data_o  <= '0;
      pay_valid_o <= 1'b0;
      pay_last_o  <= 1'b0;
      hdr_valid_o <= 1'b0;
      op_err_o    <= 1'b0;
      len_err_o   <= 1'b0;
      abort_o     <= 1'b0;
    end else begin
      hdr_valid_o <= 1'b0;
      op_err_o    <= 1'b0;
      len_err_o   <= 1'b0;
      abort_o     <= 1'b0;
      if (pay_valid_o && pay_ready_i) begin
        pay_valid_o <= 1'b0;
        pay_last_o  <= 1'b0;
      end
      if (accept) begin
        case (state)
          S_IDLE: begin
            op_r  <= rx_data_i;
            state <= S_RSV;
          end
          S_RSV: state <= S_LEN_LO;
          S_LEN_LO: begin
            len_lo <= rx_data_i;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            opcode_o <= op_r;
            len_o    <= len_w;
            rem      <= len_w - 16'(HDR_BYTES);
            if (len_w < 16'(HDR_BYTES) || len_w > MAX_LEN) begin
              len_err_o <= 1'b1;
              state     <= S_IDLE;
            end else if (!op_known(op_r)) begin
              op_err_o <= 1'b1;
              state    <= (len_w == 16'(HDR_BYTES)) ? S_IDLE : S_DRAIN;
            end else begin
              hdr_valid_o <= 1'b1;
              state       <= (len_w == 16'(HDR_BYTES)) ? S_IDLE : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            pay_data_o  <= rx_data_i;
            pay_valid_o <= 1'b1;
            pay_last_o  <= (rem == 16'd1);
            rem         <= rem - 16'd1;
            state       <= (rem == 16'd1) ? S_IDLE : S_PAYLOAD;
          end
          S_DRAIN: begin
            rem   <= rem - 16'd1;
            state <= (rem == 16'd1) ? S_IDLE : S_DRAIN;
          end
          default: state <= S_IDLE;
        endcase
      end else if (expired) begin
        abort_o     <= 1'b1;
        state       <= S_IDLE;
        pay_valid_o <= 1'b0;
        pay_last_o  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_pkt_parser.sv
// tb_uart_pkt_parser: randomized self-checking bench against a packet-level reference model
module tb_uart_pkt_parser;
  import uart_pkt_parser_pkg::*;
  localparam logic [15:0] MAX_LEN = 16'd1024;
  localparam logic [31:0] TMO = 32'd1000;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        hdr_valid_o;
  logic [7:0]  opcode_o;
  logic [15:0] len_o;
  logic [7:0]  pay_data_o;
  logic        pay_valid_o;
  logic        pay_ready_i = 1'b1;
  logic        pay_last_o;
  logic        op_err_o;
  logic        len_err_o;
  logic        abort_o;
  int tests = 0;
  int fails = 0;
  logic [23:0] obs_hdr[$];
  logic [23:0] exp_hdr[$];
  logic [8:0]  obs_beat[$];
  logic [8:0]  exp_beat[$];
  int obs_op, obs_len, obs_abort, exp_op, exp_len;
  bit rnd_ready = 1'b0;

  uart_pkt_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .hdr_valid_o(hdr_valid_o), .opcode_o(opcode_o), .len_o(len_o),
    .pay_data_o(pay_data_o), .pay_valid_o(pay_valid_o), .pay_ready_i(pay_ready_i),
    .pay_last_o(pay_last_o), .op_err_o(op_err_o), .len_err_o(len_err_o), .abort_o(abort_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // observe pulses and completed payload handshakes away from the active edge
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (hdr_valid_o) obs_hdr.push_back({opcode_o, len_o});
      if (op_err_o) obs_op++;
      if (len_err_o) obs_len++;
      if (abort_o) obs_abort++;
      if (pay_valid_o && pay_ready_i) obs_beat.push_back({pay_last_o, pay_data_o});
    end
  end

  // random downstream stalls when enabled
  always @(posedge clk_i) begin
    #1;
    if (rnd_ready) pay_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic clear();
    obs_hdr.delete(); exp_hdr.delete(); obs_beat.delete(); exp_beat.delete();
    obs_op = 0; obs_len = 0; obs_abort = 0; exp_op = 0; exp_len = 0;
  endtask

  // reference: walk the byte stream packet by packet using the protocol rules
  function automatic void model(input logic [7:0] s[$]);
    int i = 0;
    int n;
    logic [7:0] op;
    logic [15:0] len;
    while (i + 4 <= s.size()) begin
      op = s[i];
      len = {s[i+3], s[i+2]};
      n = int'(len);
      i += 4;
      if (n < 4 || n > int'(MAX_LEN)) exp_len++;
      else begin
        if (!(op inside {8'hEC, 8'hAD, 8'h88, 8'h8D})) exp_op++;
        else begin
          exp_hdr.push_back({op, len});
          for (int k = 0; k < n - 4; k++) exp_beat.push_back({k == n - 5, s[i+k]});
        end
        i += n - 4;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    while (!rx_ready_o && n < 3000) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL send_byte: rx_ready_o stayed 0, byte %h not accepted", b);
    end
    @(posedge clk_i);
    #1 rx_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], $urandom_range(0, 2));
  endtask

  task automatic settle();
    repeat (4) @(posedge clk_i);
    #2;
    rnd_ready = 1'b0;
    pay_ready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    tests++;
    if ({hdr_valid_o, op_err_o, len_err_o, abort_o, pay_valid_o, pay_last_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset pulses: got %b, expected 000000",
               {hdr_valid_o, op_err_o, len_err_o, abort_o, pay_valid_o, pay_last_o});
    end
    tests++;
    if (opcode_o !== 8'h00 || len_o !== 16'h0000) begin
      fails++;
      $display("FAIL reset hdr: got op %h len %h, expected 00 0000", opcode_o, len_o);
    end
    #1 rst_ni = 1'b1;
    tests++;
    if (rx_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset rx_ready: got %b, expected 1", rx_ready_o);
    end
  endtask

  task automatic test_echo();
    logic [7:0] s[$];
    s = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h42, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    clear(); model(s); send_stream(s); settle();
    tests++;
    if (obs_hdr.size() != exp_hdr.size() || obs_beat.size() != exp_beat.size()) begin
      fails++;
      $display("FAIL echo counts: got hdr %0d beats %0d, expected hdr %0d beats %0d",
               obs_hdr.size(), obs_beat.size(), exp_hdr.size(), exp_beat.size());
    end else begin
      foreach (exp_hdr[i]) begin
        tests++;
        if (obs_hdr[i] !== exp_hdr[i]) begin fails++; $display("FAIL echo hdr[%0d]: got %h, expected %h", i, obs_hdr[i], exp_hdr[i]); end
      end
      foreach (exp_beat[i]) begin
        tests++;
        if (obs_beat[i] !== exp_beat[i]) begin fails++; $display("FAIL echo beat[%0d]: got %h, expected %h", i, obs_beat[i], exp_beat[i]); end
      end
    end
    tests++;
    if (obs_op != 0 || obs_len != 0 || obs_abort != 0 || opcode_o !== 8'hEC || len_o !== 16'd12) begin
      fails++;
      $display("FAIL echo status: got op_err %0d len_err %0d abort %0d op %h len %0d, expected 0 0 0 ec 12",
               obs_op, obs_len, obs_abort, opcode_o, len_o);
    end
  endtask

  task automatic test_add();
    logic [7:0] s[$];
    s = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    clear(); model(s); send_stream(s); settle();
    tests++;
    if (obs_hdr.size() != exp_hdr.size() || obs_beat.size() != exp_beat.size()) begin
      fails++;
      $display("FAIL add counts: got hdr %0d beats %0d, expected hdr %0d beats %0d",
               obs_hdr.size(), obs_beat.size(), exp_hdr.size(), exp_beat.size());
    end else begin
      foreach (exp_beat[i]) begin
        tests++;
        if (obs_beat[i] !== exp_beat[i]) begin fails++; $display("FAIL add beat[%0d]: got %h, expected %h", i, obs_beat[i], exp_beat[i]); end
      end
    end
    tests++;
    if (obs_op != 0 || obs_len != 0 || opcode_o !== 8'hAD) begin
      fails++;
      $display("FAIL add status: got op_err %0d len_err %0d op %h, expected 0 0 ad", obs_op, obs_len, opcode_o);
    end
  endtask

  task automatic test_unknown_op();
    logic [7:0] s[$];
    s = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB,
          8'hEC, 8'h00, 8'h0C, 8'h00, 8'h42, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    clear(); model(s); send_stream(s); settle();
    tests++;
    if (obs_op != exp_op || obs_hdr.size() != exp_hdr.size() || obs_beat.size() != exp_beat.size()) begin
      fails++;
      $display("FAIL unknown_op counts: got op_err %0d hdr %0d beats %0d, expected %0d %0d %0d",
               obs_op, obs_hdr.size(), obs_beat.size(), exp_op, exp_hdr.size(), exp_beat.size());
    end else begin
      foreach (exp_beat[i]) begin
        tests++;
        if (obs_beat[i] !== exp_beat[i]) begin fails++; $display("FAIL unknown_op beat[%0d]: got %h, expected %h", i, obs_beat[i], exp_beat[i]); end
      end
    end
  endtask

  task automatic test_len_err();
    logic [7:0] s[$];
    s = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E,
          8'h8D, 8'h00, 8'h01, 8'h04, 8'h88, 8'h00, 8'h04, 8'h00};
    clear(); model(s); send_stream(s); settle();
    tests++;
    if (obs_len != exp_len || obs_op != exp_op || obs_hdr.size() != exp_hdr.size() || obs_beat.size() != exp_beat.size()) begin
      fails++;
      $display("FAIL len_err counts: got len_err %0d op_err %0d hdr %0d beats %0d, expected %0d %0d %0d %0d",
               obs_len, obs_op, obs_hdr.size(), obs_beat.size(), exp_len, exp_op, exp_hdr.size(), exp_beat.size());
    end else begin
      foreach (exp_hdr[i]) begin
        tests++;
        if (obs_hdr[i] !== exp_hdr[i]) begin fails++; $display("FAIL len_err hdr[%0d]: got %h, expected %h", i, obs_hdr[i], exp_hdr[i]); end
      end
      foreach (exp_beat[i]) begin
        tests++;
        if (obs_beat[i] !== exp_beat[i]) begin fails++; $display("FAIL len_err beat[%0d]: got %h, expected %h", i, obs_beat[i], exp_beat[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s[$];
    int high = 0;
    s = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h42, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    clear(); model(s);
    for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    pay_ready_i = 1'b0;
    rx_data_i = s[6];
    rx_valid_i = 1'b1;
    repeat (1200) begin
      @(negedge clk_i);
      if (rx_ready_o) high++;
    end
    tests++;
    if (high != 0) begin fails++; $display("FAIL backpressure rx_ready: got high for %0d cycles, expected 0", high); end
    tests++;
    if (pay_valid_o !== 1'b1 || pay_data_o !== 8'h69 || obs_abort != 0) begin
      fails++;
      $display("FAIL backpressure hold: got valid %b data %h aborts %0d, expected 1 69 0", pay_valid_o, pay_data_o, obs_abort);
    end
    @(posedge clk_i);
    #1 pay_ready_i = 1'b1;
    for (int i = 6; i < 12; i++) send_byte(s[i], $urandom_range(0, 2));
    settle();
    tests++;
    if (obs_beat.size() != exp_beat.size()) begin
      fails++;
      $display("FAIL backpressure beats: got %0d, expected %0d", obs_beat.size(), exp_beat.size());
    end else begin
      foreach (exp_beat[i]) begin
        tests++;
        if (obs_beat[i] !== exp_beat[i]) begin fails++; $display("FAIL backpressure beat[%0d]: got %h, expected %h", i, obs_beat[i], exp_beat[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] s[$];
    int n = 0;
    s = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
    clear();
    for (int i = 0; i < 5; i++) send_byte(s[i], $urandom_range(0, 2));
    send_byte(s[5], 0);
    while (!abort_o && n < 3000) begin
      @(posedge clk_i);
      #1 n++;
    end
    tests++;
    if (n != int'(TMO)) begin fails++; $display("FAIL timeout latency: got abort after %0d cycles, expected %0d", n, TMO); end
    tests++;
    if (pay_valid_o !== 1'b0) begin fails++; $display("FAIL timeout pay_valid: got %b, expected 0", pay_valid_o); end
    settle();
    tests++;
    if (obs_abort != 1 || obs_beat.size() != 2 || obs_hdr.size() != 1) begin
      fails++;
      $display("FAIL timeout events: got aborts %0d beats %0d hdr %0d, expected 1 2 1", obs_abort, obs_beat.size(), obs_hdr.size());
    end else begin
      tests++;
      if (obs_beat[0] !== 9'h011 || obs_beat[1] !== 9'h022) begin
        fails++;
        $display("FAIL timeout beats: got %h %h, expected 011 022", obs_beat[0], obs_beat[1]);
      end
    end
    test_echo();
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$];
    s = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h42};
    clear();
    for (int i = 0; i < 4; i++) send_byte(s[i], 0);
    pay_ready_i = 1'b0;
    send_byte(s[4], 2);
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({pay_valid_o, pay_last_o, hdr_valid_o, op_err_o, len_err_o, abort_o} !== 6'b0 || opcode_o !== 8'h00 || len_o !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid: got valid %b last %b op %h len %h, expected 0 0 00 0000", pay_valid_o, pay_last_o, opcode_o, len_o);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    pay_ready_i = 1'b1;
    test_echo();
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    logic [7:0] op;
    int len;
    int kind;
    logic [7:0] ops[4];
    ops = '{8'hEC, 8'hAD, 8'h88, 8'h8D};
    for (int p = 0; p < 30; p++) begin
      kind = $urandom_range(0, 9);
      op = ops[$urandom_range(0, 3)];
      len = $urandom_range(4, 16);
      if (kind == 0) len = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(1025, 4000);
      if (kind == 1) begin
        op = 8'($urandom_range(0, 255));
        if (op_known(op)) op = 8'h00;
      end
      s.push_back(op);
      s.push_back(8'($urandom_range(0, 255)));
      s.push_back(8'(len));
      s.push_back(8'(len >> 8));
      if (len >= 4 && len <= int'(MAX_LEN))
        for (int k = 0; k < len - 4; k++) s.push_back(8'($urandom_range(0, 255)));
    end
    clear(); model(s);
    rnd_ready = 1'b1;
    send_stream(s);
    settle();
    tests++;
    if (obs_hdr.size() != exp_hdr.size() || obs_beat.size() != exp_beat.size() || obs_op != exp_op || obs_len != exp_len || obs_abort != 0) begin
      fails++;
      $display("FAIL random counts: got hdr %0d beats %0d op_err %0d len_err %0d abort %0d, expected %0d %0d %0d %0d 0",
               obs_hdr.size(), obs_beat.size(), obs_op, obs_len, obs_abort,
               exp_hdr.size(), exp_beat.size(), exp_op, exp_len);
    end else begin
      foreach (exp_hdr[i]) begin
        tests++;
        if (obs_hdr[i] !== exp_hdr[i]) begin fails++; $display("FAIL random hdr[%0d]: got %h, expected %h", i, obs_hdr[i], exp_hdr[i]); end
      end
      foreach (exp_beat[i]) begin
        tests++;
        if (obs_beat[i] !== exp_beat[i]) begin fails++; $display("FAIL random beat[%0d]: got %h, expected %h", i, obs_beat[i], exp_beat[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_add();
    test_unknown_op();
    test_len_err();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
